// File: rtl/mux_stim_pkg.sv
// mux_stim_pkg: shared state type, sizes and the 4:1 mux reference function
// used by mux_stim_checker.
package mux_stim_pkg;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam int VEC_W   = 6;
    localparam int NUM_VEC = 64;
    localparam int CNT_W   = 7;

    // Vector layout is {s1,s0,i3,i2,i1,i0}; the mux selects i[{s1,s0}].
    function automatic logic mux_expected(input logic [VEC_W-1:0] v);
        logic [3:0] d;
        d = v[3:0];
        return d[v[5:4]];
    endfunction

endpackage

// File: rtl/mux_stim_checker.sv
// mux_stim_checker: sweeps all 64 mux input vectors, lets each settle, then
// counts mismatches of the BFG and standard-cell mux outputs.
module mux_stim_checker
    import mux_stim_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] stim,
    input  logic             bfg_in,
    input  logic             gf_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] bfg_err_cnt,
    output logic [CNT_W-1:0] gf_err_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam int SETTLE_W = 4;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    idx_q, idx_d;
    logic [VEC_W-1:0]    stim_q, stim_d;
    logic [VEC_W-1:0]    ffv_q, ffv_d;
    logic                ffval_q, ffval_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    bfg_q, bfg_d;
    logic [CNT_W-1:0]    gf_q, gf_d;
    logic                exp_bit, bfg_miss, gf_miss;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        cnt_d    = cnt_q;
        bfg_d    = bfg_q;
        gf_d     = gf_q;
        ffv_d    = ffv_q;
        ffval_d  = ffval_q;
        exp_bit  = mux_expected(stim_q);
        bfg_miss = bfg_in != exp_bit;
        gf_miss  = gf_in != exp_bit;
        // abort outranks start; in IDLE it simply keeps the block parked
        if (abort) begin
            state_d = IDLE;
            stim_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_d   = '0;
                        bfg_d   = '0;
                        gf_d    = '0;
                        ffval_d = 1'b0;
                        state_d = APPLY;
                    end
                end
                APPLY: begin
                    stim_d  = idx_q;
                    cnt_d   = SETTLE_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
                SETTLE: begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    bfg_d = bfg_q + CNT_W'(bfg_miss);
                    gf_d  = gf_q + CNT_W'(gf_miss);
                    if (!ffval_q && (bfg_miss || gf_miss)) begin
                        ffv_d   = stim_q;
                        ffval_d = 1'b1;
                    end
                    idx_d   = idx_q + 1'b1;
                    state_d = idx_q == VEC_W'(NUM_VEC - 1) ? DONE : APPLY;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            bfg_q   <= '0;
            gf_q    <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            bfg_q   <= bfg_d;
            gf_q    <= gf_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = state_q inside {APPLY, SETTLE, SAMPLE};
    assign done             = state_q == DONE;
    assign pass             = done && bfg_q == '0 && gf_q == '0;
    assign bfg_err_cnt      = bfg_q;
    assign gf_err_cnt       = gf_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_mux_stim_checker.sv
// tb_mux_stim_checker: randomized sweeps of a faulty-mux model against a
// queue-based scoreboard, plus abort, reset and back-to-back restart cases.
module tb_mux_stim_checker;

    typedef struct {
        int bfg;
        int gf;
        int ffv;
        bit ffval;
        bit pass;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0;
    logic [5:0] stim_a, stim_b, ffv_a, ffv_b;
    logic [6:0] bc_a, gc_a, bc_b, gc_b;
    logic       busy_a, done_a, pass_a, fval_a;
    logic       busy_b, done_b, pass_b, fval_b;
    logic       bfg_a, gf_a, bfg_b, gf_b;
    logic [63:0] bf_a = '0, gfm_a = '0, bf_b = '0, gfm_b = '0;

    int   tests = 0, fails = 0;
    int   cyc_a = 0, cyc_b = 0;
    logic done_a_q = 1'b0, done_b_q = 1'b0;
    exp_t exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    // Golden 4:1 mux: output is input bit number {s1,s0}.
    function automatic bit ref_out(input int v);
        return bit'((v >> ((v >> 4) & 3)) & 1);
    endfunction

    // Fault masks flip the model mux output for the marked vectors.
    assign bfg_a = ref_out(int'(stim_a)) ^ bf_a[stim_a];
    assign gf_a  = ref_out(int'(stim_a)) ^ gfm_a[stim_a];
    assign bfg_b = ref_out(int'(stim_b)) ^ bf_b[stim_b];
    assign gf_b  = ref_out(int'(stim_b)) ^ gfm_b[stim_b];

    mux_stim_checker u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .abort(abort_a),
        .stim(stim_a), .bfg_in(bfg_a), .gf_in(gf_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .bfg_err_cnt(bc_a), .gf_err_cnt(gc_a),
        .first_fail_vec(ffv_a), .first_fail_valid(fval_a)
    );

    mux_stim_checker #(.SETTLE_CYCLES(1)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .abort(1'b0),
        .stim(stim_b), .bfg_in(bfg_b), .gf_in(gf_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .bfg_err_cnt(bc_b), .gf_err_cnt(gc_b),
        .first_fail_vec(ffv_b), .first_fail_valid(fval_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] bf, input logic [63:0] gf, input int settle);
        exp_t e;
        e.bfg = 0; e.gf = 0; e.ffv = 0; e.ffval = 0;
        e.cyc = 64 * (settle + 2);
        for (int v = 0; v < 64; v++) begin
            e.bfg += int'(bf[v]);
            e.gf  += int'(gf[v]);
            if ((bf[v] || gf[v]) && !e.ffval) begin
                e.ffval = 1;
                e.ffv   = v;
            end
        end
        e.pass = e.bfg == 0 && e.gf == 0;
        return e;
    endfunction

    function automatic logic [63:0] stuck0_mask();
        logic [63:0] m;
        for (int v = 0; v < 64; v++) m[v] = ref_out(v);
        return m;
    endfunction

    task automatic check_sweep(input string tag, input exp_t e, input int cyc,
                               input logic [6:0] bc, input logic [6:0] gc, input logic [5:0] fv,
                               input logic fval, input logic ps);
        chk({tag, "_cycles"}, cyc, e.cyc);
        chk({tag, "_bfg_cnt"}, bc, e.bfg);
        chk({tag, "_gf_cnt"}, gc, e.gf);
        chk({tag, "_ff_valid"}, fval, e.ffval);
        if (e.ffval) chk({tag, "_ff_vec"}, fv, e.ffv);
        chk({tag, "_pass"}, ps, e.pass);
    endtask

    // Monitor: on each rising done, pop the expected result for that instance.
    always @(negedge clk) begin
        if (busy_a) cyc_a++;
        else begin
            if (done_a && !done_a_q) begin
                chk("a_pending", exp_a.size() > 0, 1);
                if (exp_a.size() > 0)
                    check_sweep("a", exp_a.pop_front(), cyc_a, bc_a, gc_a, ffv_a, fval_a, pass_a);
            end
            cyc_a = 0;
        end
        if (busy_b) cyc_b++;
        else begin
            if (done_b && !done_b_q) begin
                chk("b_pending", exp_b.size() > 0, 1);
                if (exp_b.size() > 0)
                    check_sweep("b", exp_b.pop_front(), cyc_b, bc_b, gc_b, ffv_b, fval_b, pass_b);
            end
            cyc_b = 0;
        end
        done_a_q = done_a;
        done_b_q = done_b;
    end

    task automatic wait_done_a(input int n);
        int k = 0;
        while (!done_a && k < n) begin
            @(negedge clk);
            k++;
        end
        chk("a_done_reached", done_a, 1);
    endtask

    task automatic sweep_a(input logic [63:0] bf, input logic [63:0] gf);
        bf_a  = bf;
        gfm_a = gf;
        exp_a.push_back(model(bf, gf, 4));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(1000);
        @(negedge clk);
        chk("a_done_held", done_a, 1);
    endtask

    initial begin
        int k, nb, eb, efv;
        bit seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stim", stim_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_bfg_cnt", bc_a, 0);
        chk("rst_gf_cnt", gc_a, 0);
        chk("rst_ff_vec", ffv_a, 0);
        chk("rst_ff_valid", fval_a, 0);

        // Back-to-back sweeps with start held; stuck-at-0 BFG must read 32 every time.
        bf_b = stuck0_mask();
        gfm_b = '0;
        repeat (3) exp_b.push_back(model(bf_b, gfm_b, 1));
        start_b = 1'b1;
        k = 0;
        nb = 0;
        while (nb < 3 && k < 2000) begin
            @(negedge clk);
            k++;
            if (done_b) nb++;
        end
        start_b = 1'b0;
        chk("b_sweep_count", nb, 3);

        sweep_a('0, '0);
        sweep_a(stuck0_mask(), '0);
        sweep_a('0, '1);
        repeat (3) sweep_a({$urandom, $urandom} & {$urandom, $urandom},
                           {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        sweep_a({$urandom, $urandom}, '0);

        // Abort while vector 10 is on the mux: vectors 0..9 have been sampled.
        bf_a  = stuck0_mask();
        gfm_a = '0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (stim_a != 6'd10 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_stim10_reached", stim_a, 10);
        eb = 0;
        efv = 0;
        seen = 0;
        for (int v = 0; v < 10; v++) begin
            eb += int'(bf_a[v]);
            if (bf_a[v] && !seen) begin
                seen = 1;
                efv = v;
            end
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_stim", stim_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_bfg_cnt", bc_a, eb);
        chk("abort_gf_cnt", gc_a, 0);
        chk("abort_ff_valid", fval_a, 1);
        chk("abort_ff_vec", ffv_a, efv);

        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy_a, 0);
        chk("start_abort_done", done_a, 0);
        chk("start_abort_stim", stim_a, 0);

        // Reset in the middle of a faulty sweep, then a clean sweep.
        bf_a  = {$urandom, $urandom};
        gfm_a = {$urandom, $urandom};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_stim", stim_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_pass", pass_a, 0);
        chk("midrst_bfg_cnt", bc_a, 0);
        chk("midrst_gf_cnt", gc_a, 0);
        chk("midrst_ff_vec", ffv_a, 0);
        chk("midrst_ff_valid", fval_a, 0);
        sweep_a('0, '0);

        repeat (2) @(negedge clk);
        chk("a_leftover", exp_a.size(), 0);
        chk("b_leftover", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
